uart_tx_ctrl: RTL and testbench

Transmit-side controller for the UART. Drains bytes from the TX byte FIFO through its rd_en/rd_data/empty port and serialises each byte onto the tx line as an 8N1 frame, or 8E1/8O1 with parity compiled in. It owns the FIFO read sequencing, the bit-period timing and the frame state machine. It sits between the TX FIFO and the UART pad.

---
 rtl/uart_pkg.sv | 45 ++++
 rtl/uart_baud_cnt.sv | 52 +++++
 rtl/uart_tx_ctrl.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit path.
//   uart_tx_state_e : frame state machine encoding (PARITY exists only when
//                     UART_TX_PARITY_EN is defined)
//   DATA_BITS       : data bits per frame
//   START_LVL       : line level of the start bit
//   STOP_LVL        : line level of the stop bit and of the idle line
//   calc_parity     : parity bit for a byte, even or odd
// Optional feature macro: UART_TX_PARITY_EN
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } uart_tx_state_e;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    STOP   = 3'd6
  } uart_tx_state_e;
`endif

  // Even parity is the XOR of all data bits; odd parity is its inverse.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                       input logic                 odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// ---------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period down-counter for the UART transmitter. A load pulse seeds the
// counter for the first bit of a frame; while running it counts down to zero
// and reloads the latched period at every bit boundary, so a period never
// wraps mid-bit.
// Ports:
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   load      in   seed the counter with load_val this cycle
//   load_val  in   DIV_W  first-bit period minus one
//   run       in   count while high
//   period    in   DIV_W  latched period minus one, used for reloads
//   cnt       out  DIV_W  current count (cycles left in this bit)
//   bit_tick  out  high in the last cycle of each bit period
// ---------------------------------------------------------------------------
module uart_baud_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             run,
  input  logic [DIV_W-1:0] period,
  output logic [DIV_W-1:0] cnt,
  output logic             bit_tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign bit_tick = run && (cnt_q == '0);
  assign cnt      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (run) begin
      cnt_d = (cnt_q == '0) ? period : cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmit controller. Pops bytes from the TX FIFO and serialises each
// one onto tx as an 8N1 frame (8E1/8O1 when UART_TX_PARITY_EN is defined).
// All outputs are registered; next-cycle values are computed from the next
// state so the line never glitches.
// Ports:
//   clk           in   system clock
//   rst_n         in   synchronous active-low reset
//   tx_en         in   allows a new frame to start
//   baud_div      in   DIV_W  bit period minus one, latched per frame
//   fifo_empty    in   TX FIFO empty flag
//   fifo_rd_en    out  one-cycle FIFO read strobe per frame
//   fifo_rd_data  in   8  FIFO data, valid the cycle after fifo_rd_en
//   parity_odd    in   odd (1) / even (0) parity, UART_TX_PARITY_EN only
//   tx            out  serial line, idles high
//   busy          out  high whenever a frame is in progress
//   frame_done    out  pulse in the last cycle of the stop bit
// Optional feature macro: UART_TX_PARITY_EN
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [7:0]       fifo_rd_data,
`ifdef UART_TX_PARITY_EN
  input  logic             parity_odd,
`endif
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  import uart_pkg::*;

  uart_tx_state_e          state_q, state_d;
  logic [DATA_BITS-1:0]    shift_q, shift_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [DIV_W-1:0]        period_q, period_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    rd_en_q, rd_en_d;
  logic                    frame_done_q, frame_done_d;
`ifdef UART_TX_PARITY_EN
  logic                    par_q, par_d;
`endif

  logic [DIV_W-1:0]        cnt;
  logic                    bit_tick;
  logic                    cnt_run;

  assign cnt_run = (state_q == START) || (state_q == DATA) ||
`ifdef UART_TX_PARITY_EN
                   (state_q == PARITY) ||
`endif
                   (state_q == STOP);

  // The first bit is seeded straight from baud_div in LOAD, the same value
  // that lands in period_q, so both agree for the whole frame.
  uart_baud_cnt #(.DIV_W(DIV_W)) u_baud_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_q == LOAD),
    .load_val (baud_div),
    .run      (cnt_run),
    .period   (period_q),
    .cnt      (cnt),
    .bit_tick (bit_tick)
  );

  // Next-state and datapath logic. Outputs are derived from the next state
  // so that they appear in the same cycle the state register changes.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    period_d  = period_q;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE:  if (tx_en && !fifo_empty) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d   = fifo_rd_data;
        period_d  = baud_div;
        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
        par_d     = calc_parity(fifo_rd_data, parity_odd);
`endif
        state_d   = START;
      end
      START: if (bit_tick) state_d = DATA;
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_tick) state_d = STOP;
`endif
      STOP: begin
        if (bit_tick) state_d = (tx_en && !fifo_empty) ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = START_LVL;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = STOP_LVL;
    endcase

    busy_d  = (state_d != IDLE);
    rd_en_d = (state_d == FETCH);

    // Predict the last stop cycle: either the stop bit is a single cycle
    // long, or the counter is one step away from zero inside STOP.
    frame_done_d = (state_d == STOP) &&
                   (((state_q != STOP) && (period_q == '0)) ||
                    ((state_q == STOP) && (cnt == DIV_W'(1))));
  end

  // Single state/output register bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      period_q     <= '0;
      tx_q         <= STOP_LVL;
      busy_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      period_q     <= period_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      rd_en_q      <= rd_en_d;
      frame_done_q <= frame_done_d;
`ifdef UART_TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_rd_en = rd_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Scoreboard bench for uart_tx_ctrl. Every byte written into the modelled
// FIFO pushes its expected frame (data, bit period, parity sense) onto a
// queue; an independent line monitor pops an entry whenever a start bit
// appears and compares the line, busy, frame_done and fifo_rd_en cycle by
// cycle against the frame rebuilt from those fields.
// Optional feature macro: UART_TX_PARITY_EN
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  typedef struct {
    logic [7:0] data;
    int         div;
    logic       par_odd;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_en = 1'b0;
  logic [15:0] baud_div = '0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = '0;
  logic        parity_odd = 1'b0;
  logic        tx, busy, frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model
  logic [7:0] fifo_q[$];
  int         fifo_cnt = 0;
  int         total_pushed = 0;
  assign fifo_empty = (fifo_cnt == 0);

  // Scoreboard and monitor state
  item_t sb[$];
  item_t cur;
  logic  exp_bits [0:11];
  int    nbits = 10;
  int    cycle = 0;
  int    rd_cnt = 0;
  int    rd_cycle = -100;
  int    bit_idx_m = 0;
  int    cyc_in_bit = 0;
  bit    in_frame = 1'b0;
  bit    post = 1'b0;
  bit    follow = 1'b0;
  logic  rst_s = 1'b0;

  uart_tx_ctrl #(.DIV_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_en        (tx_en),
    .baud_div     (baud_div),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
`ifdef UART_TX_PARITY_EN
    .parity_odd   (parity_odd),
`endif
    .tx           (tx),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  // Reset value as seen by the DUT at the most recent rising edge.
  always @(posedge clk) rst_s <= rst_n;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic model_parity(input logic [7:0] d, input logic odd);
    int ones;
    ones = $countones(d);
    return ((ones % 2) == 1) ^ odd;
  endfunction

  // FIFO read port: pop on the strobe, present data from the following cycle.
  always @(negedge clk) begin
    logic [7:0] popped;
    if (fifo_rd_en === 1'b1) begin
      checkOutput("rd_while_nonempty", (fifo_cnt != 0), 1);
      if (fifo_cnt != 0) begin
        popped = fifo_q.pop_front();
        fifo_cnt--;
        @(posedge clk);
        #1 fifo_rd_data = popped;
        @(posedge clk);
        #1 fifo_rd_data = 8'($urandom);
      end
    end
  end

  // Line monitor / scoreboard consumer.
  always @(negedge clk) begin
    cycle++;
    if (!rst_s) begin
      in_frame = 1'b0;
      post     = 1'b0;
      checkOutput("reset_tx", tx, 1);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_frame_done", frame_done, 0);
      checkOutput("reset_rd_en", fifo_rd_en, 0);
    end else begin
      if (post) begin
        checkOutput("busy_after_frame", busy, follow);
        checkOutput("rd_en_after_frame", fifo_rd_en, follow);
        post = 1'b0;
      end
      if (!in_frame) begin
        checkOutput("frame_done_idle", frame_done, 0);
        if (fifo_rd_en === 1'b1) begin
          rd_cnt++;
          rd_cycle = cycle;
        end
        if (tx === 1'b0) begin
          checkOutput("sb_has_item", (sb.size() != 0), 1);
          if (sb.size() != 0) begin
            cur = sb.pop_front();
            exp_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) exp_bits[i+1] = cur.data[i];
`ifdef UART_TX_PARITY_EN
            exp_bits[9]  = model_parity(cur.data, cur.par_odd);
            exp_bits[10] = 1'b1;
            nbits = 11;
`else
            exp_bits[9] = 1'b1;
            nbits = 10;
`endif
            checkOutput("start_latency", cycle - rd_cycle, 2);
            in_frame   = 1'b1;
            bit_idx_m  = 0;
            cyc_in_bit = 0;
          end
        end
      end
      if (in_frame) begin
        checkOutput("tx_bit", tx, exp_bits[bit_idx_m]);
        checkOutput("busy_in_frame", busy, 1);
        checkOutput("rd_en_in_frame", fifo_rd_en, 0);
        checkOutput("frame_done", frame_done,
                    (bit_idx_m == nbits - 1) && (cyc_in_bit == cur.div));
        cyc_in_bit++;
        if (cyc_in_bit > cur.div) begin
          cyc_in_bit = 0;
          bit_idx_m++;
          if (bit_idx_m == nbits) begin
            in_frame = 1'b0;
            post     = 1'b1;
            follow   = tx_en && (fifo_cnt != 0);
          end
        end
      end
    end
  end

  // Drives control inputs just after a rising edge.
  task automatic applyStimulus(input logic en, input int div, input logic podd);
    @(posedge clk);
    #1;
    tx_en      = en;
    baud_div   = div[15:0];
    parity_odd = podd;
  endtask

  // Writes a byte into the FIFO model and records its expected frame.
  task automatic pushByte(input logic [7:0] data);
    item_t it;
    it.data    = data;
    it.div     = int'(baud_div);
    it.par_odd = parity_odd;
    fifo_q.push_back(data);
    fifo_cnt++;
    sb.push_back(it);
    total_pushed++;
  endtask

  task automatic waitIdle(input int limit);
    int k;
    k = 0;
    while ((fifo_cnt != 0 || sb.size() != 0 || in_frame || post) && k < limit) begin
      @(posedge clk);
      k++;
    end
    checkOutput("drain_timeout", (k < limit), 1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int r0;
    int k;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("init_tx", tx, 1);
    checkOutput("init_busy", busy, 0);
    checkOutput("init_rd_en", fifo_rd_en, 0);
    checkOutput("init_frame_done", frame_done, 0);
    rst_n = 1'b1;

    // Single byte 0xA5, 4 cycles per bit
    $display("[TB] single byte");
    applyStimulus(1'b1, 3, 1'b0);
    r0 = rd_cnt;
    pushByte(8'hA5);
    waitIdle(300);
    checkOutput("single_rd_count", rd_cnt - r0, 1);

    // Back-to-back 0x00 / 0xFF at 1 cycle per bit
    $display("[TB] back-to-back");
    applyStimulus(1'b1, 0, 1'b0);
    r0 = rd_cnt;
    pushByte(8'h00);
    pushByte(8'hFF);
    waitIdle(300);
    checkOutput("b2b_rd_count", rd_cnt - r0, 2);

    // Empty FIFO, then disabled with data present
    $display("[TB] empty and disabled");
    applyStimulus(1'b1, 2, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checkOutput("empty_tx", tx, 1);
      checkOutput("empty_rd_en", fifo_rd_en, 0);
      checkOutput("empty_busy", busy, 0);
    end
    applyStimulus(1'b0, 2, 1'b0);
    pushByte(8'h5A);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checkOutput("disabled_tx", tx, 1);
      checkOutput("disabled_rd_en", fifo_rd_en, 0);
      checkOutput("disabled_busy", busy, 0);
    end
    applyStimulus(1'b1, 2, 1'b0);
    waitIdle(300);

    // Mid-frame baud change and tx_en drop
    $display("[TB] mid-frame disturbances");
    applyStimulus(1'b1, 7, 1'b0);
    r0 = rd_cnt;
    pushByte(8'h3C);
    k = 0;
    while (!(in_frame && bit_idx_m >= 3) && k < 500) begin
      @(posedge clk);
      k++;
    end
    checkOutput("reach_data_bits", (k < 500), 1);
    applyStimulus(1'b0, 1, 1'b0);
    pushByte(8'h55);
    k = 0;
    while ((in_frame || post) && k < 500) begin
      @(posedge clk);
      k++;
    end
    checkOutput("frame_completes", (k < 500), 1);
    repeat (30) @(posedge clk);
    checkOutput("no_second_read", rd_cnt - r0, 1);
    applyStimulus(1'b1, 1, 1'b0);
    waitIdle(300);

    // Reset during data bit 4
    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 3, 1'b0);
    pushByte(8'hC3);
    k = 0;
    while (!(in_frame && bit_idx_m == 5) && k < 500) begin
      @(posedge clk);
      k++;
    end
    checkOutput("reach_bit4", (k < 500), 1);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset_tx", tx, 1);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_frame_done", frame_done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pushByte(8'h96);
    waitIdle(300);

    // Parity sense: 0x07 even then odd
    $display("[TB] parity");
    applyStimulus(1'b1, 2, 1'b0);
    pushByte(8'h07);
    waitIdle(300);
    applyStimulus(1'b1, 2, 1'b1);
    pushByte(8'h07);
    waitIdle(300);

    // Randomised batches
    $display("[TB] random batches");
    for (int b = 0; b < 8; b++) begin
      int n;
      applyStimulus(1'b1, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
      n = int'($urandom_range(1, 4));
      for (int j = 0; j < n; j++) pushByte(8'($urandom));
      waitIdle(2000);
    end

    checkOutput("rd_total", rd_cnt, total_pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
